// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared formats, field positions, opcodes and FSM states for the instruction encoder
package instr_pkg;

    // Format select codes carried on in_fmt
    localparam logic [1:0] FMT_R    = 2'd0;
    localparam logic [1:0] FMT_I    = 2'd1;
    localparam logic [1:0] FMT_J    = 2'd2;
    localparam logic [1:0] FMT_MOVE = 2'd3;

    // Field positions inside a 32-bit MIPS word
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int SH_MSB  = 10;
    localparam int SH_LSB  = 6;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int TGT_MSB = 25;
    localparam int TGT_LSB = 0;

    // Opcodes the format check cares about
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } enc_state_t;

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational packer from per-field description to 32-bit MIPS word
module instr_pack
    import instr_pkg::*;
(
    input  logic [1:0]  fmt_i,
    input  logic [5:0]  op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] target26_i,
    output logic [31:0] word_o
);

    // Place only the fields the selected format uses; everything else stays zero
    always_comb begin
        word_o = 32'h0;
        word_o[OP_MSB:OP_LSB] = op_i;
        case (fmt_i)
            FMT_R: begin
                word_o[RS_MSB:RS_LSB] = rs_i;
                word_o[RT_MSB:RT_LSB] = rt_i;
                word_o[RD_MSB:RD_LSB] = rd_i;
                word_o[SH_MSB:SH_LSB] = shamt_i;
                word_o[FN_MSB:FN_LSB] = funct_i;
            end
            FMT_I: begin
                word_o[RS_MSB:RS_LSB]   = rs_i;
                word_o[RT_MSB:RT_LSB]   = rt_i;
                word_o[IMM_MSB:IMM_LSB] = imm16_i;
            end
            FMT_J: begin
                word_o[TGT_MSB:TGT_LSB] = target26_i;
            end
            default: begin
                // MOVE: rs slot is forced to zero, rs input ignored
                word_o[RT_MSB:RT_LSB]   = rt_i;
                word_o[IMM_MSB:IMM_LSB] = imm16_i;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streams packed instruction words with addresses to imem; optional INSTR_ENC_CHECK_EN format check
module instr_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic              in_last,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm16,
    input  logic [25:0]       in_target26,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              wrapped,
    output logic              err
);

    localparam logic [ADDR_W:0]   WC_MAX   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_TOP = {ADDR_W{1'b1}};

    enc_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] addr_next;
    logic              out_valid_q;
    logic [31:0]       out_word_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              last_q;
    logic [ADDR_W:0]   word_count_q;
    logic              wrapped_q;
    logic [31:0]       packed_word;
    logic              accept;
    logic              emit;

    instr_pack u_pack (
        .fmt_i      (in_fmt),
        .op_i       (in_op),
        .rs_i       (in_rs),
        .rt_i       (in_rt),
        .rd_i       (in_rd),
        .shamt_i    (in_shamt),
        .funct_i    (in_funct),
        .imm16_i    (in_imm16),
        .target26_i (in_target26),
        .word_o     (packed_word)
    );

    // Handshake qualifiers; load_start blocks acceptance so a reload never races a new word
    always_comb begin
        in_ready  = (state_q == ST_RUN) && !load_start && (!out_valid_q || out_ready);
        accept    = in_valid && in_ready;
        emit      = out_valid_q && out_ready;
        addr_inc  = addr_q + ADDR_W'(1);
        addr_next = emit ? addr_inc : addr_q;
    end

    // Next-state logic: reload wins from any state, RUN ends when the last word leaves
    always_comb begin
        state_d = state_q;
        if (load_start) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:  if (emit && last_q) state_d = ST_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // One-entry output stage: load on accept, drain on emit, flush on reload
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_word_q  <= 32'h0;
            out_addr_q  <= '0;
            last_q      <= 1'b0;
        end else if (load_start) begin
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_word_q  <= packed_word;
            out_addr_q  <= addr_next;
            last_q      <= in_last;
        end else if (emit) begin
            out_valid_q <= 1'b0;
        end
    end

    // Address counter, saturating word counter and sticky wrap flag
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            word_count_q <= '0;
            wrapped_q    <= 1'b0;
        end else if (load_start) begin
            addr_q       <= start_addr;
            word_count_q <= '0;
            wrapped_q    <= 1'b0;
        end else if (emit) begin
            addr_q <= addr_inc;
            if (word_count_q != WC_MAX) word_count_q <= word_count_q + (ADDR_W+1)'(1);
            if (addr_q == ADDR_TOP) wrapped_q <= 1'b1;
        end
    end

`ifdef INSTR_ENC_CHECK_EN
    logic err_q;
    logic fmt_bad;

    // R words must carry the R-type opcode; J words must be J or JAL
    always_comb begin
        fmt_bad = ((in_fmt == FMT_R) && (in_op != OP_RTYPE)) ||
                  ((in_fmt == FMT_J) && (in_op != OP_J) && (in_op != OP_JAL));
    end

    // Sticky error, cleared only by reset or reload
    always_ff @(posedge clk) begin
        if (rst || load_start)    err_q <= 1'b0;
        else if (accept && fmt_bad) err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign out_valid  = out_valid_q;
    assign out_word   = out_word_q;
    assign out_addr   = out_addr_q;
    assign word_count = word_count_q;
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign wrapped    = wrapped_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [7:0]  start_addr;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_fmt;
    logic        in_last;
    logic [5:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm16;
    logic [25:0] in_target26;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [7:0]  out_addr;
    logic [8:0]  word_count;
    logic        busy, done, wrapped, err;

    int total = 0;
    int bad   = 0;

`ifdef INSTR_ENC_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    instr_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .start_addr(start_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_last(in_last),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm16(in_imm16), .in_target26(in_target26),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_addr(out_addr),
        .word_count(word_count), .busy(busy), .done(done), .wrapped(wrapped), .err(err)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                         input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tgt,
                         input logic last);
        in_fmt = f; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_funct = fn; in_imm16 = imm; in_target26 = tgt; in_last = last; in_valid = 1'b1;
    endtask

    task automatic pulse_load(input logic [7:0] a);
        load_start = 1'b1;
        start_addr = a;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL load_in_ready got=%0b want=0", in_ready);
        end
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; load_start = 1'b0; start_addr = 8'h0; in_valid = 1'b0; out_ready = 1'b1;
        drive(2'd0, 6'h0, 5'h0, 5'h0, 5'h0, 5'h0, 6'h0, 16'h0, 26'h0, 1'b0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({out_valid, out_word, out_addr, word_count, done, wrapped, err, busy, in_ready} !== '0) begin
            bad++;
            $display("FAIL reset_state got v=%0b w=%h a=%h c=%0d d=%0b wr=%0b e=%0b b=%0b r=%0b want all 0",
                     out_valid, out_word, out_addr, word_count, done, wrapped, err, busy, in_ready);
        end
    endtask

    task automatic test_r_word;
        out_ready = 1'b1;
        pulse_load(8'h10);
        drive(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hBEEF, 26'h155, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_word !== 32'h00221820 || out_addr !== 8'h10) begin
            bad++; $display("FAIL r_word got v=%0b w=%h a=%h want 1 00221820 10", out_valid, out_word, out_addr);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || word_count !== 9'd1 || busy !== 1'b1) begin
            bad++; $display("FAIL r_count got v=%0b c=%0d b=%0b want 0 1 1", out_valid, word_count, busy);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        pulse_load(8'h10);
        drive(2'd1, 6'h08, 5'd0, 5'd5, 5'd7, 5'd3, 6'h3F, 16'hFFFF, 26'h0, 1'b0);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_word !== 32'h2005FFFF || out_addr !== 8'h10) begin
            bad++; $display("FAIL b2b_i got v=%0b w=%h a=%h want 1 2005ffff 10", out_valid, out_word, out_addr);
        end
        drive(2'd2, 6'h02, 5'd9, 5'd9, 5'd9, 5'd9, 6'h11, 16'h1111, 26'h0000100, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_word !== 32'h08000100 || out_addr !== 8'h11) begin
            bad++; $display("FAIL b2b_j got v=%0b w=%h a=%h want 1 08000100 11", out_valid, out_word, out_addr);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || word_count !== 9'd2 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_done got d=%0b b=%0b c=%0d r=%0b v=%0b want 1 0 2 0 0",
                            done, busy, word_count, in_ready, out_valid);
        end
    endtask

    task automatic test_stall;
        out_ready = 1'b0;
        pulse_load(8'h20);
        drive(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0);
        @(negedge clk);
        drive(2'd1, 6'h08, 5'd0, 5'd5, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_word !== 32'h00221820 || out_addr !== 8'h20) begin
                bad++; $display("FAIL stall_hold[%0d] got r=%0b v=%0b w=%h a=%h want 0 1 00221820 20",
                                i, in_ready, out_valid, out_word, out_addr);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL stall_release_ready got=%0b want=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_word !== 32'h2005FFFF || out_addr !== 8'h21 || word_count !== 9'd1) begin
            bad++; $display("FAIL stall_next got v=%0b w=%h a=%h c=%0d want 1 2005ffff 21 1",
                            out_valid, out_word, out_addr, word_count);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || word_count !== 9'd2) begin
            bad++; $display("FAIL stall_drain got v=%0b c=%0d want 0 2", out_valid, word_count);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] exp_a [3];
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
        out_ready = 1'b1;
        pulse_load(8'hFE);
        drive(2'd3, 6'h0F, 5'h1F, 5'd4, 5'd6, 5'd6, 6'h2A, 16'h1234, 26'h3FFFFFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_word !== 32'h3C041234 || out_addr !== exp_a[i]) begin
                bad++; $display("FAIL wrap_word[%0d] got v=%0b w=%h a=%h want 1 3c041234 %h",
                                i, out_valid, out_word, out_addr, exp_a[i]);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (wrapped !== 1'b1 || word_count !== 9'd3 || busy !== 1'b1) begin
            bad++; $display("FAIL wrap_flag got wr=%0b c=%0d b=%0b want 1 3 1", wrapped, word_count, busy);
        end
    endtask

    task automatic test_load_abort;
        out_ready = 1'b0;
        drive(2'd1, 6'h08, 5'd0, 5'd5, 5'd0, 5'd0, 6'h0, 16'hAAAA, 26'h0, 1'b0);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_word !== 32'h2005AAAA || out_addr !== 8'h01) begin
            bad++; $display("FAIL abort_pending got v=%0b w=%h a=%h want 1 2005aaaa 01", out_valid, out_word, out_addr);
        end
        drive(2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h3FFFFFF, 1'b0);
        pulse_load(8'h40);
        total++;
        if (out_valid !== 1'b0 || wrapped !== 1'b0 || word_count !== 9'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL abort_flush got v=%0b wr=%0b c=%0d b=%0b want 0 0 0 1",
                            out_valid, wrapped, word_count, busy);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_word !== 32'h0FFFFFFF || out_addr !== 8'h40) begin
            bad++; $display("FAIL abort_next got v=%0b w=%h a=%h want 1 0fffffff 40", out_valid, out_word, out_addr);
        end
        @(negedge clk);
        total++;
        if (word_count !== 9'd1 || wrapped !== 1'b0) begin
            bad++; $display("FAIL abort_count got c=%0d wr=%0b want 1 0", word_count, wrapped);
        end
    endtask

    task automatic test_err;
        out_ready = 1'b1;
        pulse_load(8'h50);
        drive(2'd0, 6'h08, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0);
        @(negedge clk);
        drive(2'd1, 6'h08, 5'd0, 5'd5, 5'd0, 5'd0, 6'h0, 16'h0001, 26'h0, 1'b0);
        total++;
        if (out_word !== 32'h20221820 || out_addr !== 8'h50 || err !== CHK) begin
            bad++; $display("FAIL err_set got w=%h a=%h e=%0b want 20221820 50 %0b", out_word, out_addr, err, CHK);
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (out_word !== 32'h20050001 || err !== CHK) begin
            bad++; $display("FAIL err_sticky got w=%h e=%0b want 20050001 %0b", out_word, err, CHK);
        end
        pulse_load(8'h60);
        total++;
        if (err !== 1'b0) begin
            bad++; $display("FAIL err_clear got=%0b want=0", err);
        end
        drive(2'd2, 6'h04, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000010, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (out_word !== 32'h10000010 || out_addr !== 8'h60 || err !== CHK) begin
            bad++; $display("FAIL err_j got w=%h a=%h e=%0b want 10000010 60 %0b", out_word, out_addr, err, CHK);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || word_count !== 9'd1) begin
            bad++; $display("FAIL err_done got d=%0b c=%0d want 1 1", done, word_count);
        end
    endtask

    initial begin
        test_reset;
        test_r_word;
        test_back_to_back;
        test_stall;
        test_wrap;
        test_load_abort;
        test_err;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
